// File: rtl/log_dump_ctrl.sv
// Capture/dump sequencer for the two-bank sample logger: arms a capture, waits for a
// fresh full flag, then reads every logger word and streams it MSB-first as bytes.
module log_dump_ctrl #(
   parameter int BRAM_ADDR_WIDTH = 15,
   parameter int LOG_DATA_WIDTH  = 32
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_cmd_start,
   input  logic                       i_cmd_dump,
   output logic                       o_run_log,
   output logic                       o_read_log,
   output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
   input  logic                       i_mem_full,
   input  logic [LOG_DATA_WIDTH-1:0]  i_data_log,
   output logic [7:0]                 o_tx_data,
   output logic                       o_tx_valid,
   input  logic                       i_tx_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [2:0]                 o_state
);

   // TX handshake: a byte moves on every cycle where o_tx_valid && i_tx_ready; while
   // valid is high and ready is low, o_tx_data and o_tx_valid hold their values.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_CAPTURE = 3'd2,
      S_READY   = 3'd3,
      S_ADDR    = 3'd4,
      S_RD      = 3'd5,
      S_SEND    = 3'd6
   } state_e;

   state_e                       state_q, state_d;
   logic                         seen_low_q, seen_low_d;
   logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LOG_DATA_WIDTH-1:0]    word_q, word_d;
   logic [1:0]                   k_q, k_d;
   logic [7:0]                   tx_data_q, tx_data_d;
   logic                         tx_valid_q, tx_valid_d;
   logic                         done_q, done_d;

   logic [1:0]                   k_inc;
   logic [7:0]                   next_byte;
   logic                         byte_accept;
   logic                         last_addr;

   assign byte_accept = tx_valid_q && i_tx_ready;
   assign last_addr   = (addr_q == {BRAM_ADDR_WIDTH{1'b1}});

   always_comb begin
      k_inc     = k_q + 2'd1;
      next_byte = word_q[31:24];
      case (k_inc)
         2'd0:    next_byte = word_q[31:24];
         2'd1:    next_byte = word_q[23:16];
         2'd2:    next_byte = word_q[15:8];
         default: next_byte = word_q[7:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      seen_low_d = seen_low_q;
      addr_d     = addr_q;
      word_d     = word_q;
      k_d        = k_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_cmd_start) begin
               state_d = S_ARM;
            end
         end

         S_ARM: begin
            seen_low_d = 1'b0;
            state_d    = S_CAPTURE;
         end

         // A full flag left over from the previous capture must drop before it counts.
         S_CAPTURE: begin
            if (!i_mem_full) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               state_d = S_READY;
            end
         end

         S_READY: begin
            if (i_cmd_start) begin
               state_d = S_ARM;
            end else if (i_cmd_dump) begin
               addr_d  = '0;
               state_d = S_ADDR;
            end
         end

         S_ADDR: begin
            state_d = S_RD;
         end

         S_RD: begin
            word_d     = i_data_log;
            k_d        = 2'd0;
            tx_data_d  = i_data_log[31:24];
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
         end

         S_SEND: begin
            if (byte_accept) begin
               if (k_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  if (last_addr) begin
                     done_d  = 1'b1;
                     state_d = S_READY;
                  end else begin
                     addr_d  = addr_q + BRAM_ADDR_WIDTH'(1);
                     state_d = S_ADDR;
                  end
               end else begin
                  k_d       = k_inc;
                  tx_data_d = next_byte;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         seen_low_q <= 1'b0;
         addr_q     <= '0;
         word_q     <= '0;
         k_q        <= 2'd0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seen_low_q <= seen_low_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         k_q        <= k_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
      end
   end

   assign o_run_log  = (state_q == S_ARM);
   assign o_read_log = (state_q == S_ADDR) || (state_q == S_RD) || (state_q == S_SEND);
   assign o_addr_log = addr_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_valid = tx_valid_q;
   assign o_busy     = !((state_q == S_IDLE) || (state_q == S_READY));
   assign o_done     = done_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_log_dump_ctrl.sv
// Bench for log_dump_ctrl with an 8-word logger model; bytes accepted on the TX
// handshake are scored against streams queued when each dump is commanded.
module tb_log_dump_ctrl;

   localparam int AW     = 3;
   localparam int BUDGET = 2000;

   logic          clk;
   logic          i_rst;
   logic          i_cmd_start;
   logic          i_cmd_dump;
   logic          o_run_log;
   logic          o_read_log;
   logic [AW-1:0] o_addr_log;
   logic          i_mem_full;
   logic [31:0]   i_data_log;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic          o_busy;
   logic          o_done;
   logic [2:0]    o_state;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         rd_idx     = 0;
   int         stall_seen = 0;
   int         stall_err  = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'd0;

   log_dump_ctrl #(.BRAM_ADDR_WIDTH(AW), .LOG_DATA_WIDTH(32)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_cmd_start (i_cmd_start),
      .i_cmd_dump  (i_cmd_dump),
      .o_run_log   (o_run_log),
      .o_read_log  (o_read_log),
      .o_addr_log  (o_addr_log),
      .i_mem_full  (i_mem_full),
      .i_data_log  (i_data_log),
      .o_tx_data   (o_tx_data),
      .o_tx_valid  (o_tx_valid),
      .i_tx_ready  (i_tx_ready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_state     (o_state)
   );

   // Clock and logger memory model: read data appears one cycle after the address.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) i_data_log <= 32'hA0B1C200 + {29'd0, o_addr_log};

   // Monitor: records accepted bytes and checks that stalled bytes stay put.
   always @(negedge clk) begin
      if (i_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            stall_seen++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== prev_data) stall_err++;
         end
         if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) got_q.push_back(o_tx_data);
         prev_stall = (o_tx_valid === 1'b1) && (i_tx_ready !== 1'b1);
         prev_data  = o_tx_data;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump_bytes;
      for (int a = 0; a < (1 << AW); a++) begin
         exp_q.push_back(8'hA0);
         exp_q.push_back(8'hB1);
         exp_q.push_back(8'hC2);
         exp_q.push_back(8'(a));
      end
   endtask

   task automatic pulse_dump;
      i_cmd_dump = 1'b1;
      tick;
      i_cmd_dump = 1'b0;
   endtask

   task automatic wait_done(input bit rand_ready, output int cyc, output int runs);
      cyc  = 0;
      runs = 0;
      while (cyc < BUDGET && o_done !== 1'b1) begin
         if (rand_ready) i_tx_ready = ($urandom_range(0, 9) < 3);
         tick;
         cyc++;
         if (o_run_log === 1'b1) runs++;
      end
      i_tx_ready = 1'b1;
   endtask

   task automatic do_capture;
      int n;
      i_mem_full  = 1'b1;
      i_cmd_start = 1'b1;
      tick;
      i_cmd_start = 1'b0;
      tick;
      i_mem_full = 1'b0;
      repeat (3) tick;
      i_mem_full = 1'b1;
      n = 0;
      while (n < 20 && o_state !== 3'd3) begin
         tick;
         n++;
      end
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (3) tick;
      i_rst = 1'b0;
      total_cnt++;
      if (o_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", o_state); else pass_cnt++;
      total_cnt++;
      if (o_run_log !== 1'b0 || o_read_log !== 1'b0) $display("FAIL reset_run_read: got %b%b want 00", o_run_log, o_read_log); else pass_cnt++;
      total_cnt++;
      if (o_addr_log !== 3'd0) $display("FAIL reset_addr: got %0d want 0", o_addr_log); else pass_cnt++;
      total_cnt++;
      if (o_tx_data !== 8'd0 || o_tx_valid !== 1'b0) $display("FAIL reset_tx: got %02h/%b want 00/0", o_tx_data, o_tx_valid); else pass_cnt++;
      total_cnt++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", o_busy, o_done); else pass_cnt++;
   endtask

   task automatic test_capture;
      int early;
      i_mem_full  = 1'b1;
      i_cmd_start = 1'b1;
      tick;
      i_cmd_start = 1'b0;
      total_cnt++;
      if (o_run_log !== 1'b1 || o_state !== 3'd1) $display("FAIL capture_arm: got run=%b state=%0d want run=1 state=1", o_run_log, o_state); else pass_cnt++;
      tick;
      total_cnt++;
      if (o_run_log !== 1'b0 || o_state !== 3'd2) $display("FAIL capture_run_pulse: got run=%b state=%0d want run=0 state=2", o_run_log, o_state); else pass_cnt++;
      early = 0;
      repeat (2) begin
         tick;
         if (o_state !== 3'd2) early++;
      end
      i_mem_full = 1'b0;
      repeat (20) begin
         tick;
         if (o_state !== 3'd2) early++;
      end
      total_cnt++;
      if (early !== 0) $display("FAIL capture_stale_full: got %0d cycles outside CAPTURE want 0", early); else pass_cnt++;
      i_mem_full = 1'b1;
      tick;
      total_cnt++;
      if (o_state !== 3'd3) $display("FAIL capture_ready: got %0d want 3", o_state); else pass_cnt++;
      total_cnt++;
      if (o_busy !== 1'b0) $display("FAIL capture_busy: got %b want 0", o_busy); else pass_cnt++;
   endtask

   task automatic test_dump;
      int cyc, runs;
      logic [7:0] e;
      i_tx_ready = 1'b1;
      push_dump_bytes();
      pulse_dump();
      total_cnt++;
      if (o_state !== 3'd4 || o_addr_log !== 3'd0 || o_read_log !== 1'b1)
         $display("FAIL dump_first_addr: got state=%0d addr=%0d read=%b want 4/0/1", o_state, o_addr_log, o_read_log);
      else pass_cnt++;
      wait_done(1'b0, cyc, runs);
      total_cnt++;
      if (cyc !== 48) $display("FAIL dump_latency: got %0d cycles want 48", cyc); else pass_cnt++;
      total_cnt++;
      if (o_state !== 3'd3 || o_addr_log !== 3'd7) $display("FAIL dump_end_state: got state=%0d addr=%0d want 3/7", o_state, o_addr_log); else pass_cnt++;
      total_cnt++;
      if (o_tx_valid !== 1'b0 || o_read_log !== 1'b0 || o_busy !== 1'b0)
         $display("FAIL dump_end_flags: got valid=%b read=%b busy=%b want 000", o_tx_valid, o_read_log, o_busy);
      else pass_cnt++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= got_q.size()) $display("FAIL dump_byte: got none want %02h", e);
         else begin
            if (got_q[rd_idx] !== e) $display("FAIL dump_byte %0d: got %02h want %02h", rd_idx, got_q[rd_idx], e); else pass_cnt++;
            rd_idx++;
         end
      end
      total_cnt++;
      if (rd_idx != got_q.size()) $display("FAIL dump_extra: got %0d bytes want %0d", got_q.size(), rd_idx); else pass_cnt++;
      tick;
      total_cnt++;
      if (o_done !== 1'b0) $display("FAIL dump_done_pulse: got %b want 0", o_done); else pass_cnt++;
   endtask

   task automatic test_backpressure;
      int cyc, runs;
      logic [7:0] e;
      push_dump_bytes();
      pulse_dump();
      wait_done(1'b1, cyc, runs);
      total_cnt++;
      if (cyc >= BUDGET) $display("FAIL bp_timeout: got %0d cycles want < %0d", cyc, BUDGET); else pass_cnt++;
      total_cnt++;
      if (stall_err !== 0) $display("FAIL bp_stall_hold: got %0d unstable stalls want 0", stall_err); else pass_cnt++;
      total_cnt++;
      if (stall_seen == 0) $display("FAIL bp_stalls: got 0 stall cycles want > 0"); else pass_cnt++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= got_q.size()) $display("FAIL bp_byte: got none want %02h", e);
         else begin
            if (got_q[rd_idx] !== e) $display("FAIL bp_byte %0d: got %02h want %02h", rd_idx, got_q[rd_idx], e); else pass_cnt++;
            rd_idx++;
         end
      end
      total_cnt++;
      if (rd_idx != got_q.size()) $display("FAIL bp_extra: got %0d bytes want %0d", got_q.size(), rd_idx); else pass_cnt++;
      total_cnt++;
      if (o_state !== 3'd3 || o_addr_log !== 3'd7) $display("FAIL bp_end_state: got state=%0d addr=%0d want 3/7", o_state, o_addr_log); else pass_cnt++;
   endtask

   task automatic test_collisions;
      int cyc, runs, n;
      logic [7:0] e;
      // start during SEND is ignored
      push_dump_bytes();
      pulse_dump();
      n = 0;
      while (n < 20 && o_state !== 3'd6) begin
         tick;
         n++;
      end
      i_cmd_start = 1'b1;
      tick;
      i_cmd_start = 1'b0;
      total_cnt++;
      if (o_run_log !== 1'b0 || o_busy !== 1'b1) $display("FAIL coll_start_in_send: got run=%b busy=%b want 0/1", o_run_log, o_busy); else pass_cnt++;
      wait_done(1'b0, cyc, runs);
      total_cnt++;
      if (cyc >= BUDGET || runs !== 0) $display("FAIL coll_send_complete: got cyc=%0d runs=%0d want done with 0 runs", cyc, runs); else pass_cnt++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (rd_idx >= got_q.size()) $display("FAIL coll_byte: got none want %02h", e);
         else begin
            if (got_q[rd_idx] !== e) $display("FAIL coll_byte %0d: got %02h want %02h", rd_idx, got_q[rd_idx], e); else pass_cnt++;
            rd_idx++;
         end
      end
      total_cnt++;
      if (rd_idx != got_q.size()) $display("FAIL coll_extra: got %0d bytes want %0d", got_q.size(), rd_idx); else pass_cnt++;
      // start and dump together in READY: start wins
      i_cmd_start = 1'b1;
      i_cmd_dump  = 1'b1;
      tick;
      i_cmd_start = 1'b0;
      i_cmd_dump  = 1'b0;
      total_cnt++;
      if (o_state !== 3'd1 || o_run_log !== 1'b1 || o_read_log !== 1'b0)
         $display("FAIL coll_both_ready: got state=%0d run=%b read=%b want 1/1/0", o_state, o_run_log, o_read_log);
      else pass_cnt++;
      tick;
      // dump during CAPTURE is ignored (full still stale-high)
      pulse_dump();
      total_cnt++;
      if (o_state !== 3'd2 || o_read_log !== 1'b0) $display("FAIL coll_dump_in_capture: got state=%0d read=%b want 2/0", o_state, o_read_log); else pass_cnt++;
      i_mem_full = 1'b0;
      tick;
      i_mem_full = 1'b1;
      tick;
      total_cnt++;
      if (o_state !== 3'd3) $display("FAIL coll_capture_ready: got %0d want 3", o_state); else pass_cnt++;
      // dump in IDLE is ignored
      i_rst = 1'b1;
      tick;
      i_rst = 1'b0;
      pulse_dump();
      tick;
      total_cnt++;
      if (o_state !== 3'd0 || o_read_log !== 1'b0 || o_tx_valid !== 1'b0)
         $display("FAIL coll_dump_in_idle: got state=%0d read=%b valid=%b want 0/0/0", o_state, o_read_log, o_tx_valid);
      else pass_cnt++;
      do_capture();
      total_cnt++;
      if (o_state !== 3'd3) $display("FAIL coll_recapture: got %0d want 3", o_state); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int cyc, runs;
      logic [7:0] e;
      for (int r = 0; r < 2; r++) begin
         push_dump_bytes();
         pulse_dump();
         wait_done(1'b0, cyc, runs);
         total_cnt++;
         if (cyc !== 48 || runs !== 0) $display("FAIL repeat_%0d_timing: got cyc=%0d runs=%0d want 48/0", r, cyc, runs); else pass_cnt++;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (rd_idx >= got_q.size()) $display("FAIL repeat_byte: got none want %02h", e);
            else begin
               if (got_q[rd_idx] !== e) $display("FAIL repeat_byte %0d: got %02h want %02h", rd_idx, got_q[rd_idx], e); else pass_cnt++;
               rd_idx++;
            end
         end
         total_cnt++;
         if (rd_idx != got_q.size()) $display("FAIL repeat_extra: got %0d bytes want %0d", got_q.size(), rd_idx); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_send;
      int n;
      pulse_dump();
      n = 0;
      while (n < 100 && !(o_state === 3'd6 && o_addr_log === 3'd3)) begin
         tick;
         n++;
      end
      total_cnt++;
      if (n >= 100) $display("FAIL rst_mid_reach: got state=%0d addr=%0d want 6/3", o_state, o_addr_log); else pass_cnt++;
      i_rst = 1'b1;
      tick;
      total_cnt++;
      if (o_state !== 3'd0 || o_tx_valid !== 1'b0) $display("FAIL rst_mid_state: got state=%0d valid=%b want 0/0", o_state, o_tx_valid); else pass_cnt++;
      total_cnt++;
      if (o_read_log !== 1'b0 || o_addr_log !== 3'd0 || o_busy !== 1'b0)
         $display("FAIL rst_mid_outputs: got read=%b addr=%0d busy=%b want 0/0/0", o_read_log, o_addr_log, o_busy);
      else pass_cnt++;
      i_rst  = 1'b0;
      rd_idx = got_q.size();
      exp_q.delete();
   endtask

   initial begin
      i_rst       = 1'b1;
      i_cmd_start = 1'b0;
      i_cmd_dump  = 1'b0;
      i_mem_full  = 1'b0;
      i_tx_ready  = 1'b1;
      test_reset();
      test_capture();
      test_dump();
      test_backpressure();
      test_collisions();
      test_back_to_back();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/log_dump_ctrl.md
# log_dump_ctrl

Sequencer for the two-bank sample logger: starts a capture, waits for the logger to report full, then sweeps every logger address, reads each 32-bit word (bank B in bits [31:16], bank A in bits [15:0]) and streams it out byte-by-byte over a valid/ready handshake towards the UART TX path. It sits between the host command decoder and the logger memory. It owns the logger's run, read and address inputs exclusively.

## Interface
- BRAM_ADDR_WIDTH, 15, logger address width; dump length is 2^BRAM_ADDR_WIDTH words.
- LOG_DATA_WIDTH, 32, logger read word width; fixed at 32 (4 bytes per word).

- clk  in  1  single system clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_cmd_start  in  1  one-cycle pulse: start a new capture.
- i_cmd_dump  in  1  one-cycle pulse: dump the captured log.
- o_run_log  out  1  to logger run input; one-cycle pulse.
- o_read_log  out  1  to logger read input; high for the whole dump.
- o_addr_log  out  BRAM_ADDR_WIDTH  to logger address input; registered.
- i_mem_full  in  1  from logger full flag.
- i_data_log  in  32  from logger read data; valid 1 cycle after address.
- o_tx_data  out  8  byte to TX.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  TX accepts byte.
- o_busy  out  1  high in any state except IDLE and READY.
- o_done  out  1  one-cycle pulse when the last byte of a dump is accepted.
- o_state  out  3  current state code, for debug.

## Operation
- States and codes: IDLE=0, ARM=1, CAPTURE=2, READY=3, ADDR=4, RD=5, SEND=6.
- IDLE: i_cmd_start goes to ARM. i_cmd_dump is ignored.
- ARM: lasts 1 cycle. o_run_log=1, seen_low flag is cleared, then the block goes to CAPTURE.
- CAPTURE: sets seen_low when i_mem_full==0. When seen_low and i_mem_full==1, goes to READY. This prevents a stale full flag from a previous capture ending the capture early.
- CAPTURE ignores both commands.
- READY: i_cmd_dump clears the address to 0 and goes to ADDR. i_cmd_start goes to ARM.
- If both commands arrive in the same READY cycle, start wins.
- ADDR: lasts 1 cycle; the logger samples o_addr_log.
- RD: lasts 1 cycle. At its end i_data_log is latched into a 32-bit word register, byte index is set to 0, then the block goes to SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data = word[31-8k:24-8k] for byte index k, most significant byte first.
  - On each cycle with o_tx_valid && i_tx_ready, k increments.
  - When byte k=3 is accepted:
    - If o_addr_log is all-ones: pulse o_done and go to READY with the address held.
    - Otherwise: increment o_addr_log and go to ADDR.
- o_read_log=1 in ADDR, RD and SEND; 0 elsewhere.
- Commands received during ADDR, RD or SEND are ignored; they are not queued.
- The logged data is still intact in READY, so repeated dumps are allowed.
- Reset at any point, including mid-dump or mid-byte, returns the block to IDLE on the next edge. Any partially sent word is discarded.

## Timing
- Reset values: o_run_log=0, o_read_log=0, o_addr_log=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, o_state=0. seen_low, k and the word register are also 0.
- o_run_log is high exactly in the cycle after i_cmd_start is sampled.
- The read pipeline is ADDR, then RD (data valid in RD), then SEND.
- Minimum cost per word is 6 cycles (ADDR + RD + 4 SEND) with i_tx_ready tied high.
- A full dump with ready tied high takes 6·2^BRAM_ADDR_WIDTH cycles from the first ADDR to o_done.
- Handshake rules:
  - o_tx_data and o_tx_valid are registered.
  - While o_tx_valid && !i_tx_ready, o_tx_data is held stable.
  - o_tx_valid is never dropped without the byte being accepted.
  - o_tx_valid goes low in the cycle after the 4th byte of a word is accepted.
- Address wrap: o_addr_log never wraps during a dump. The last address is all-ones and ends the dump.
- o_done coincides with the cycle in which o_state returns to READY.

## Test plan
- Reset: assert i_rst mid-SEND with BRAM_ADDR_WIDTH=3 → next cycle o_state=0, o_tx_valid=0, o_read_log=0, o_addr_log=0.
- Capture:
  - Pulse i_cmd_start in IDLE → o_run_log high for exactly 1 cycle.
  - Hold i_mem_full=1 (stale) for 2 cycles, then 0 for 20 cycles, then 1 → READY is entered only on that last rise.
- Dump with ready tied high, BRAM_ADDR_WIDTH=3, model word(a)=32'hA0B1C200+a → 32 bytes out: A0,B1,C2,00,A0,B1,C2,01,…,A0,B1,C2,07.
  - o_done pulses 48 cycles after the first ADDR.
  - o_addr_log stays at 7, o_state returns to 3.
- Backpressure: drive i_tx_ready with a random 30% duty → same byte sequence, o_tx_data stable throughout every stall, no byte duplicated or lost.
- Command collisions:
  - i_cmd_dump in IDLE or CAPTURE → ignored.
  - i_cmd_start during SEND → ignored and the dump completes.
  - i_cmd_start and i_cmd_dump together in READY → ARM (o_run_log pulse), no dump.
- Repeat dump: two consecutive i_cmd_dump pulses from READY, each after the previous o_done → identical 32-byte streams with no intervening o_run_log.
